branch_pc_unit: RTL and testbench

//   PC register and branch sequencer; the downstream consumer of the CON flip-flop.
//   It increments the PC on fetch and executes br/jr/jal as a small FSM.
//   For a br it strobes the CON FF enable, samples the resulting condition bit,

---
 rtl/branch_pc_unit.sv | 189 ++++++++++++++++++
 tb/tb_branch_pc_unit.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_pc_unit.sv
// -----------------------------------------------------------------------------
// branch_pc_unit
//
// PC register and branch sequencer. It sits between the control unit
// (start/done handshake) and the PC/bus datapath, and it consumes the output
// of the CON flip-flop.
//
// While idle, the PC advances on fetch_inc_i. An accepted start_i launches a
// short sequence that depends on the opcode in ir_i[31:27]:
//   br  : strobe the CON FF enable, sample con_i, then either add the
//         sign-extended 19-bit C field to the PC or leave the PC unchanged
//   jr  : PC <= R[Ra]
//   jal : present the current PC as the link value (R15 write), then PC <= R[Ra]
//   any other opcode : finish at once and leave the PC unchanged
//
// Ports
//   clock_i      rising-edge clock
//   clear_i      asynchronous active-low reset
//   start_i      IR holds a branch/jump; sampled only in IDLE
//   fetch_inc_i  PC <= PC + 1; honoured only in IDLE when start_i is low
//   ir_i         instruction register, captured on an accepted start
//   ra_value_i   contents of R[Ra], the jump target for jr/jal
//   con_i        CON FF output (condition met), sampled in EVAL
//   con_en_o     CONIn strobe to the CON FF (state COND)
//   link_we_o    link register (R15) write strobe (state LINK)
//   link_o       return address for jal; holds until the next jal or reset
//   pc_o         current PC
//   taken_o      the last branch/jump changed the PC; held until the next start
//   busy_o       sequencer is not in IDLE
//   done_o       one-cycle completion pulse (state DONE)
//
// Latency from the start edge t to done_o being high:
//   br t+3, jr t+2, jal t+3, any other opcode t+1.
// -----------------------------------------------------------------------------
module branch_pc_unit #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter logic [4:0]       OP_BR    = 5'b10010,
  parameter logic [4:0]       OP_JR    = 5'b10011,
  parameter logic [4:0]       OP_JAL   = 5'b10100
) (
  input  logic             clock_i,
  input  logic             clear_i,
  input  logic             start_i,
  input  logic             fetch_inc_i,
  input  logic [31:0]      ir_i,
  input  logic [WIDTH-1:0] ra_value_i,
  input  logic             con_i,
  output logic             con_en_o,
  output logic             link_we_o,
  output logic [WIDTH-1:0] link_o,
  output logic [WIDTH-1:0] pc_o,
  output logic             taken_o,
  output logic             busy_o,
  output logic             done_o
);

  // Width of the branch displacement (C field, ir[18:0]).
  localparam int DISP_W = 19;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COND,
    S_EVAL,
    S_JUMP,
    S_LINK,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    pc_q,    pc_d;
  logic [WIDTH-1:0]    link_q,  link_d;
  logic                taken_q, taken_d;
  // Only the C field of the captured instruction is ever consumed after the
  // start edge (the opcode is decoded straight from ir_i), so only that field
  // is kept.
  logic [DISP_W-1:0]   disp_q,  disp_d;

  logic [4:0]          opcode;
  logic [WIDTH-1:0]    disp_sext;

  // Ra/Rb fields of the IR belong to the register-file path, not to this unit.
  logic                unused_ir;

  assign opcode    = ir_i[31:27];
  assign unused_ir = ^ir_i[26:DISP_W];
  assign disp_sext = {{(WIDTH-DISP_W){disp_q[DISP_W-1]}}, disp_q};

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned in this block receives a default first, so
    // no path can leave it unassigned and infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    link_d  = link_q;
    taken_d = taken_q;
    disp_d  = disp_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          // start has priority over fetch_inc: no increment on this edge.
          disp_d  = ir_i[DISP_W-1:0];
          taken_d = 1'b0;
          if (opcode == OP_BR) begin
            state_d = S_COND;
          end else if (opcode == OP_JR) begin
            state_d = S_JUMP;
          end else if (opcode == OP_JAL) begin
            // The PC cannot change before LINK, so the return address is
            // captured here and is already stable while link_we_o is high.
            link_d  = pc_q;
            state_d = S_LINK;
          end else begin
            state_d = S_DONE;
          end
        end else if (fetch_inc_i) begin
          pc_d = pc_q + WIDTH'(1);
        end
      end

      S_COND: begin
        state_d = S_EVAL;
      end

      S_EVAL: begin
        // The CON FF was enabled during COND, so its output is valid now.
        if (con_i) begin
          pc_d    = pc_q + disp_sext;
          taken_d = 1'b1;
        end
        state_d = S_DONE;
      end

      S_LINK: begin
        state_d = S_JUMP;
      end

      S_JUMP: begin
        pc_d    = ra_value_i;
        taken_d = 1'b1;
        state_d = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the values from before the edge.
  always_ff @(posedge clock_i or negedge clear_i) begin
    if (!clear_i) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      link_q  <= '0;
      taken_q <= 1'b0;
      disp_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      link_q  <= link_d;
      taken_q <= taken_d;
      disp_q  <= disp_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: registers or straight state decodes, no input-to-output paths.
  // ---------------------------------------------------------------------------
  assign pc_o      = pc_q;
  assign link_o    = link_q;
  assign taken_o   = taken_q;
  assign con_en_o  = (state_q == S_COND);
  assign link_we_o = (state_q == S_LINK);
  assign done_o    = (state_q == S_DONE);
  assign busy_o    = (state_q != S_IDLE);

endmodule

// File: tb/tb_branch_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_pc_unit
//
// Directed bench for branch_pc_unit. Inputs are driven 1 ns after a rising
// edge and outputs are sampled at the same point, so each step() shows the
// state reached by the edge just taken. Expected values are computed by hand
// from the intended behaviour.
// -----------------------------------------------------------------------------
module tb_branch_pc_unit;

  localparam int         WIDTH  = 32;
  localparam logic [4:0] OP_BR  = 5'b10010;
  localparam logic [4:0] OP_JR  = 5'b10011;
  localparam logic [4:0] OP_JAL = 5'b10100;
  localparam logic [4:0] OP_ADD = 5'b00011;

  logic             clock_i;
  logic             clear_i;
  logic             start_i;
  logic             fetch_inc_i;
  logic [31:0]      ir_i;
  logic [WIDTH-1:0] ra_value_i;
  logic             con_i;
  logic             con_en_o;
  logic             link_we_o;
  logic [WIDTH-1:0] link_o;
  logic [WIDTH-1:0] pc_o;
  logic             taken_o;
  logic             busy_o;
  logic             done_o;

  int n_vec  = 0;
  int n_miss = 0;

  branch_pc_unit #(
    .WIDTH   (WIDTH),
    .RESET_PC('0),
    .OP_BR   (OP_BR),
    .OP_JR   (OP_JR),
    .OP_JAL  (OP_JAL)
  ) dut (
    .clock_i    (clock_i),
    .clear_i    (clear_i),
    .start_i    (start_i),
    .fetch_inc_i(fetch_inc_i),
    .ir_i       (ir_i),
    .ra_value_i (ra_value_i),
    .con_i      (con_i),
    .con_en_o   (con_en_o),
    .link_we_o  (link_we_o),
    .link_o     (link_o),
    .pc_o       (pc_o),
    .taken_o    (taken_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  task automatic fetch(input int n);
    fetch_inc_i = 1'b1;
    repeat (n) step();
    fetch_inc_i = 1'b0;
  endtask

  function automatic logic [31:0] mk_ir(input logic [4:0] op,
                                        input logic [18:0] c);
    return {op, 8'h00, c};
  endfunction

  // Watchdog: the stimulus is fixed-length, this only guards against a hung
  // simulator scheduler.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench timed out");
  end

  initial begin
    clear_i     = 1'b0;
    start_i     = 1'b0;
    fetch_inc_i = 1'b0;
    ir_i        = '0;
    ra_value_i  = '0;
    con_i       = 1'b0;

    // ---- reset state ----
    step();
    step();
    check("rst_pc",     pc_o,      32'h0);
    check("rst_busy",   busy_o,    0);
    check("rst_done",   done_o,    0);
    check("rst_taken",  taken_o,   0);
    check("rst_link",   link_o,    32'h0);
    check("rst_con_en", con_en_o,  0);
    check("rst_linkwe", link_we_o, 0);
    clear_i = 1'b1;

    // ---- 1: reset in the middle of a br (EVAL), then three fetches ----
    ir_i    = mk_ir(OP_BR, 19'h00005);
    con_i   = 1'b1;
    start_i = 1'b1;
    step();                                   // edge t -> COND
    start_i = 1'b0;
    check("t1_con_en_cond", con_en_o, 1);
    step();                                   // -> EVAL
    check("t1_busy_eval", busy_o, 1);
    #2 clear_i = 1'b0;
    #1;
    check("t1_abort_pc",   pc_o,     32'h0);
    check("t1_abort_busy", busy_o,   0);
    check("t1_abort_con",  con_en_o, 0);
    #1 clear_i = 1'b1;
    con_i = 1'b0;
    fetch_inc_i = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      check($sformatf("t1_fetch_pc%0d", i), pc_o, 32'(i));
      check($sformatf("t1_no_done%0d", i), done_o, 0);
    end
    fetch_inc_i = 1'b0;
    fetch(13);
    check("t1_pc_0x10", pc_o, 32'h10);

    // ---- 2: br C=-4 taken from pc=0x10 ----
    ir_i    = mk_ir(OP_BR, 19'h7FFFC);
    start_i = 1'b1;
    step();                                   // t
    start_i = 1'b0;
    check("t2_con_en_t1", con_en_o, 1);
    check("t2_done_t1",   done_o,   0);
    con_i = 1'b1;
    step();                                   // EVAL
    check("t2_con_en_eval", con_en_o, 0);
    check("t2_done_t2",     done_o,   0);
    step();                                   // DONE
    con_i = 1'b0;
    check("t2_pc",    pc_o,    32'h0C);
    check("t2_taken", taken_o, 1);
    check("t2_done",  done_o,  1);
    step();
    check("t2_done_drop", done_o,  0);
    check("t2_idle",      busy_o,  0);
    check("t2_taken_hold", taken_o, 1);

    // ---- 3: same br not taken from pc=0x10 ----
    fetch(4);
    check("t3_pc_pre", pc_o, 32'h10);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    check("t3_taken_clr", taken_o, 0);
    con_i = 1'b0;
    step();
    step();
    check("t3_pc",    pc_o,    32'h10);
    check("t3_taken", taken_o, 0);
    check("t3_done",  done_o,  1);
    step();

    // ---- 4: jal from pc=0x20 to 0x100 ----
    fetch(16);
    check("t4_pc_pre", pc_o, 32'h20);
    ir_i       = mk_ir(OP_JAL, 19'h0);
    ra_value_i = 32'h100;
    start_i    = 1'b1;
    step();                                   // LINK
    start_i = 1'b0;
    check("t4_link_we",  link_we_o, 1);
    check("t4_link_out", link_o,    32'h20);
    check("t4_done_t1",  done_o,    0);
    step();                                   // JUMP
    check("t4_link_we_drop", link_we_o, 0);
    check("t4_done_t2",      done_o,    0);
    step();                                   // DONE
    check("t4_pc",    pc_o,    32'h100);
    check("t4_taken", taken_o, 1);
    check("t4_done",  done_o,  1);
    step();
    check("t4_link_hold", link_o, 32'h20);

    // ---- 5: jr to 0xFFFFFFFF, wrap on fetch, start beats fetch_inc ----
    ir_i       = mk_ir(OP_JR, 19'h0);
    ra_value_i = 32'hFFFF_FFFF;
    start_i    = 1'b1;
    step();                                   // JUMP
    start_i = 1'b0;
    check("t5_done_t1", done_o, 0);
    step();                                   // DONE at t+2
    check("t5_jr_done", done_o, 1);
    check("t5_jr_pc",   pc_o,   32'hFFFF_FFFF);
    step();
    fetch(1);
    check("t5_wrap", pc_o, 32'h0);
    ra_value_i  = 32'h40;
    start_i     = 1'b1;
    fetch_inc_i = 1'b1;
    step();
    start_i     = 1'b0;
    fetch_inc_i = 1'b0;
    check("t5_no_inc", pc_o, 32'h0);
    step();
    check("t5_pc_0x40", pc_o, 32'h40);
    check("t5_done",    done_o, 1);
    step();

    // ---- 6: non-branch opcode, then start/fetch ignored while busy ----
    ir_i    = mk_ir(OP_ADD, 19'h00123);
    start_i = 1'b1;
    step();                                   // DONE at t+1
    start_i = 1'b0;
    check("t6_add_done",  done_o,  1);
    check("t6_add_pc",    pc_o,    32'h40);
    check("t6_add_taken", taken_o, 0);
    step();
    check("t6_add_idle", busy_o, 0);

    ir_i        = mk_ir(OP_BR, 19'h00001);
    start_i     = 1'b1;
    fetch_inc_i = 1'b1;
    step();                                   // COND
    ir_i       = mk_ir(OP_JR, 19'h0);
    ra_value_i = 32'h999;
    con_i      = 1'b1;
    check("t6_busy_pc", pc_o, 32'h40);
    step();                                   // EVAL
    check("t6_eval_pc", pc_o, 32'h40);
    check("t6_eval_done", done_o, 0);
    step();                                   // DONE
    start_i     = 1'b0;
    fetch_inc_i = 1'b0;
    con_i       = 1'b0;
    check("t6_br_pc",   pc_o,   32'h41);
    check("t6_br_done", done_o, 1);
    step();
    check("t6_idle",    busy_o, 0);
    check("t6_pc_hold", pc_o,   32'h41);
    check("t6_link",    link_o, 32'h20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
